// File: rtl/week6_ex1_rr_arbiter.sv
// rtl/week6_ex1_rr_arbiter.sv - four-requester round-robin arbiter with held grants; optional forced release under RR_ARB_TIMEOUT_EN
module week6_ex1_rr_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  output logic [3:0] gnt,
  output logic [1:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Reject out-of-range hold limits at elaboration so the 8-bit counter compare stays exact
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be in 2..255");
  end

  state_t     state_q, state_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] ptr_q, ptr_d;
  logic [1:0] holder_next;
  logic [3:0] pick_idle;
  logic [3:0] pick_release;

  // First asserted request scanning from p upward with modulo-4 wrap; one-hot or zero
  function automatic logic [3:0] rr_pick(input logic [3:0] r, input logic [1:0] p);
    logic [3:0] g;
    logic [1:0] j;
    g = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      j = p + 2'(k);
      if (g == 4'b0000 && r[j]) begin
        g[j] = 1'b1;
      end
    end
    return g;
  endfunction

  // Encode the registered one-hot grant for downstream muxing
  always_comb begin
    gnt_idx = 2'b00;
    case (gnt_q)
      4'b0010: gnt_idx = 2'b01;
      4'b0100: gnt_idx = 2'b10;
      4'b1000: gnt_idx = 2'b11;
      default: gnt_idx = 2'b00;
    endcase
  end

  assign gnt         = gnt_q;
  assign gnt_valid   = |gnt_q;
  assign holder_next = gnt_idx + 2'd1;
  assign pick_idle    = rr_pick(req, ptr_q);
  assign pick_release = rr_pick(req, holder_next);

`ifdef RR_ARB_TIMEOUT_EN

  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       timeout_q, timeout_d;
  logic [3:0] pick_forced;

  // A forced release must not hand the grant straight back to the holder it just evicted
  assign pick_forced = rr_pick(req & ~gnt_q, holder_next);
  assign timeout     = timeout_q;

  // Next-state: hold, voluntary release, or forced release after HOLD_LAST counted cycles
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    timeout_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          gnt_d   = pick_idle;
          cnt_d   = 8'd0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if ((req & gnt_q) == 4'b0000) begin
          ptr_d = holder_next;
          gnt_d = pick_release;
          cnt_d = 8'd0;
          if (pick_release == 4'b0000) begin
            state_d = IDLE;
          end
        end else if (cnt_q == HOLD_LAST) begin
          ptr_d     = holder_next;
          gnt_d     = pick_forced;
          cnt_d     = 8'd0;
          timeout_d = 1'b1;
          if (pick_forced == 4'b0000) begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State, grant, priority pointer, hold counter and timeout pulse registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= 4'b0000;
      ptr_q     <= 2'd0;
      cnt_q     <= 8'd0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

`else

  assign timeout = 1'b0;

  // Next-state: a holder keeps the grant until it drops its request
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (req != 4'b0000) begin
          gnt_d   = pick_idle;
          state_d = GRANT;
        end
      end
      GRANT: begin
        if ((req & gnt_q) == 4'b0000) begin
          ptr_d = holder_next;
          gnt_d = pick_release;
          if (pick_release == 4'b0000) begin
            state_d = IDLE;
          end
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = 4'b0000;
      end
    endcase
  end

  // State, grant and priority pointer registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      ptr_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      ptr_q   <= ptr_d;
    end
  end

`endif

endmodule

// File: tb/tb_week6_ex1_rr_arbiter.sv
// tb/tb_week6_ex1_rr_arbiter.sv - randomized and directed checks of week6_ex1_rr_arbiter against a behavioural model
module tb_week6_ex1_rr_arbiter;

  localparam int MAX_HOLD = 4;
`ifdef RR_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int checks = 0;
  int failures = 0;

  // behavioural model: current holder (-1 idle), priority pointer, hold cycles, timeout pulse
  int m_hold = -1;
  int m_ptr = 0;
  int m_cnt = 0;
  int m_to = 0;

  week6_ex1_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req(req),
    .gnt(gnt),
    .gnt_idx(gnt_idx),
    .gnt_valid(gnt_valid),
    .timeout(timeout)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached got running expected finished");
    $fatal(1);
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int pick(input int r, input int p, input int excl);
    int j;
    for (int k = 0; k < 4; k++) begin
      j = (p + k) % 4;
      if (((r >> j) & 1) == 1 && j != excl) return j;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_hold = -1;
    m_ptr  = 0;
    m_cnt  = 0;
    m_to   = 0;
  endtask

  task automatic model_step(input int r);
    m_to = 0;
    if (m_hold < 0) begin
      if (r != 0) begin
        m_hold = pick(r, m_ptr, -1);
        m_cnt  = 0;
      end
    end else if (((r >> m_hold) & 1) == 0) begin
      m_ptr  = (m_hold + 1) % 4;
      m_hold = pick(r, m_ptr, -1);
      m_cnt  = 0;
    end else if (TO_EN && m_cnt == MAX_HOLD - 1) begin
      m_ptr  = (m_hold + 1) % 4;
      m_hold = pick(r, m_ptr, m_hold);
      m_cnt  = 0;
      m_to   = 1;
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, ".gnt"}, int'(gnt), (m_hold < 0) ? 0 : (1 << m_hold));
    check({tag, ".idx"}, int'(gnt_idx), (m_hold < 0) ? 0 : m_hold);
    check({tag, ".valid"}, int'(gnt_valid), (m_hold < 0) ? 0 : 1);
    check({tag, ".timeout"}, int'(timeout), m_to);
  endtask

  // Drive req for one cycle, advance the model at the edge, compare mid-cycle
  task automatic cyc(input logic [3:0] r, input string tag);
    req = r;
    @(posedge clk);
    model_step(int'(r));
    @(negedge clk);
    check_outputs(tag);
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    req = 4'b0000;
    #1;
    model_reset();
    check_outputs(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  int order[5] = '{0, 1, 2, 3, 0};
  int to_pulses;
  logic [3:0] r;

  initial begin
    // reset sanity with all requests asserted
    req = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    model_reset();
    check_outputs("rst");
    rst_n = 1'b1;
    cyc(4'b1111, "rst_first");
    check("rst_first_gnt", int'(gnt), 1);

    // encoding per requester with idle gaps
    for (int i = 0; i < 4; i++) begin
      cyc(4'(1 << i), $sformatf("enc%0d_grant", i));
      check($sformatf("enc%0d_idx", i), int'(gnt_idx), i);
      cyc(4'(1 << i), $sformatf("enc%0d_hold", i));
      cyc(4'(1 << i), $sformatf("enc%0d_hold2", i));
      cyc(4'b0000, $sformatf("enc%0d_idle", i));
      check($sformatf("enc%0d_gap", i), int'(gnt_valid), 0);
    end

    // rotation fairness, back-to-back grants
    do_reset("rot_rst");
    cyc(4'b1111, "rot_start");
    for (int n = 0; n < 5; n++) begin
      check($sformatf("rot_order%0d", n), int'(gnt_idx), order[n]);
      check($sformatf("rot_valid%0d", n), int'(gnt_valid), 1);
      cyc(4'b1111, $sformatf("rot_hold%0d", n));
      r = 4'b1111 & ~4'(1 << order[n]);
      cyc(r, $sformatf("rot_drop%0d", n));
    end

    // wrap: release of requester 2 moves ptr to 3, req=0011 must go to 0
    do_reset("wrap_rst");
    cyc(4'b0100, "wrap_g2");
    cyc(4'b0100, "wrap_h2");
    cyc(4'b0011, "wrap_rel");
    check("wrap_gnt", int'(gnt), 1);

    // asynchronous reset in the middle of a grant
    do_reset("arst_rst");
    cyc(4'b0100, "arst_g2");
    cyc(4'b0100, "arst_h2");
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_gnt_now", int'(gnt), 0);
    check("arst_valid_now", int'(gnt_valid), 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cyc(4'b0100, "arst_regrant");
    check("arst_regrant_gnt", int'(gnt), 4);

    // hold limit behaviour with req=0011 held
    do_reset("to_rst");
    cyc(4'b0011, "to_g0");
    to_pulses = 0;
    if (TO_EN) begin
      for (int k = 1; k <= 8; k++) begin
        cyc(4'b0011, $sformatf("to_c%0d", k));
        to_pulses += int'(timeout);
        if (k == 4) check("to_first_gnt", int'(gnt), 2);
        if (k == 8) check("to_second_gnt", int'(gnt), 1);
      end
      check("to_pulses", to_pulses, 2);
    end else begin
      for (int k = 1; k <= 50; k++) begin
        cyc(4'b0011, $sformatf("hold_c%0d", k));
        to_pulses += int'(timeout);
      end
      check("hold_gnt", int'(gnt), 1);
      check("hold_pulses", to_pulses, 0);
    end

    // randomized traffic with sticky requests and occasional holder drops
    do_reset("rnd_rst");
    r = 4'b0000;
    for (int n = 0; n < 400; n++) begin
      case ($urandom_range(0, 5))
        0, 1:    r = 4'($urandom_range(0, 15));
        2:       if (m_hold >= 0) r = r & ~4'(1 << m_hold);
        default: r = r;
      endcase
      cyc(r, $sformatf("rnd%0d", n));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
